// File: rtl/keccak_rc_lfsr_gen.sv
// keccak_rc_lfsr_gen: streams Keccak iota round constants built from the rc(t) LFSR, NR per start.
// Build option KECCAK_RC_PARALLEL_EN unrolls the seven LFSR steps so GEN becomes a one-cycle load.
module keccak_rc_lfsr_gen #(
  parameter int NR     = 24,
  parameter int LANE_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rc_ready,
  output logic              rc_valid,
  output logic [LANE_W-1:0] rc_data,
  output logic [4:0]        rc_round,
  output logic              rc_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [4:0] LAST_ROUND = 5'(NR - 1);

  state_t            state_q, state_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [4:0]        round_q, round_d;
  logic              rc_valid_q, rc_valid_d;
  logic [LANE_W-1:0] rc_data_q, rc_data_d;
  logic [4:0]        rc_round_q, rc_round_d;
  logic              rc_last_q, rc_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  function automatic logic [7:0] lfsr_step(input logic [7:0] r);
    logic [7:0] s;
    s = {r[6:0], 1'b0};
    if (r[7]) begin
      s = s ^ 8'h71;
    end else begin
      s = s;
    end
    return s;
  endfunction

  // Step j of a round lands on lane bit 2^j - 1.
  function automatic logic [5:0] bit_pos(input logic [2:0] j);
    logic [5:0] p;
    case (j)
      3'd0:    p = 6'd0;
      3'd1:    p = 6'd1;
      3'd2:    p = 6'd3;
      3'd3:    p = 6'd7;
      3'd4:    p = 6'd15;
      3'd5:    p = 6'd31;
      3'd6:    p = 6'd63;
      default: p = 6'd0;
    endcase
    return p;
  endfunction

`ifdef KECCAK_RC_PARALLEL_EN
  function automatic logic [71:0] build_round(input logic [7:0] r);
    logic [7:0]  s;
    logic [63:0] c;
    s = r;
    c = 64'd0;
    for (int j = 0; j < 7; j++) begin
      c[bit_pos(3'(j))] = s[0];
      s = lfsr_step(s);
    end
    return {s, c};
  endfunction

  logic [7:0]  lfsr_adv;
  logic [63:0] rc_full;

  always_comb begin
    {lfsr_adv, rc_full} = build_round(lfsr_q);
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    round_d    = round_q;
    rc_valid_d = rc_valid_q;
    rc_data_d  = rc_data_q;
    rc_round_d = rc_round_q;
    rc_last_d  = rc_last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = GEN;
          lfsr_d  = 8'h01;
          round_d = 5'd0;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      GEN: begin
        state_d    = OUT;
        lfsr_d     = lfsr_adv;
        rc_valid_d = 1'b1;
        rc_data_d  = rc_full[LANE_W-1:0];
        rc_round_d = round_q;
        rc_last_d  = (round_q == LAST_ROUND);
      end
      OUT: begin
        if (rc_ready && rc_last_q) begin
          state_d    = IDLE;
          rc_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else if (rc_ready) begin
          // Next constant is loaded on the handshake edge so rc_valid never drops.
          round_d    = round_q + 5'd1;
          lfsr_d     = lfsr_adv;
          rc_data_d  = rc_full[LANE_W-1:0];
          rc_round_d = round_q + 5'd1;
          rc_last_d  = ((round_q + 5'd1) == LAST_ROUND);
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d    = IDLE;
        rc_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lfsr_q     <= 8'h01;
      round_q    <= 5'd0;
      rc_valid_q <= 1'b0;
      rc_data_q  <= '0;
      rc_round_q <= 5'd0;
      rc_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      round_q    <= round_d;
      rc_valid_q <= rc_valid_d;
      rc_data_q  <= rc_data_d;
      rc_round_q <= rc_round_d;
      rc_last_q  <= rc_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end
`else
  logic [2:0]  step_q, step_d;
  logic [63:0] acc_q, acc_d;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    round_d    = round_q;
    step_d     = step_q;
    acc_d      = acc_q;
    rc_valid_d = rc_valid_q;
    rc_data_d  = rc_data_q;
    rc_round_d = rc_round_q;
    rc_last_d  = rc_last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = GEN;
          lfsr_d  = 8'h01;
          round_d = 5'd0;
          step_d  = 3'd0;
          acc_d   = 64'd0;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      GEN: begin
        lfsr_d                = lfsr_step(lfsr_q);
        acc_d[bit_pos(step_q)] = lfsr_q[0];
        if (step_q == 3'd6) begin
          step_d     = 3'd0;
          state_d    = OUT;
          rc_valid_d = 1'b1;
          rc_data_d  = acc_d[LANE_W-1:0];
          rc_round_d = round_q;
          rc_last_d  = (round_q == LAST_ROUND);
        end else begin
          step_d     = step_q + 3'd1;
        end
      end
      OUT: begin
        if (rc_ready && rc_last_q) begin
          state_d    = IDLE;
          rc_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else if (rc_ready) begin
          // LFSR keeps running across rounds; only the accumulator restarts.
          state_d    = GEN;
          rc_valid_d = 1'b0;
          round_d    = round_q + 5'd1;
          acc_d      = 64'd0;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d    = IDLE;
        rc_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lfsr_q     <= 8'h01;
      round_q    <= 5'd0;
      step_q     <= 3'd0;
      acc_q      <= 64'd0;
      rc_valid_q <= 1'b0;
      rc_data_q  <= '0;
      rc_round_q <= 5'd0;
      rc_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      round_q    <= round_d;
      step_q     <= step_d;
      acc_q      <= acc_d;
      rc_valid_q <= rc_valid_d;
      rc_data_q  <= rc_data_d;
      rc_round_q <= rc_round_d;
      rc_last_q  <= rc_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end
`endif

  assign rc_valid = rc_valid_q;
  assign rc_data  = rc_data_q;
  assign rc_round = rc_round_q;
  assign rc_last  = rc_last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_keccak_rc_lfsr_gen.sv
// Scoreboard bench for keccak_rc_lfsr_gen: two instances (24x64 and 12x16), expected constants
// computed from the rc(t) polynomial definition; honours KECCAK_RC_PARALLEL_EN for latency.
module tb_keccak_rc_lfsr_gen;
  localparam int NR_A = 24;
  localparam int LW_A = 64;
  localparam int NR_B = 12;
  localparam int LW_B = 16;
`ifdef KECCAK_RC_PARALLEL_EN
  localparam int LAT = 1;
  localparam int PER = 1;
`else
  localparam int LAT = 7;
  localparam int PER = 8;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_a, ready_a, valid_a, last_a, busy_a, done_a;
  logic [63:0] data_a;
  logic [4:0]  round_a;
  logic        start_b, ready_b, valid_b, last_b, busy_b, done_b;
  logic [15:0] data_b;
  logic [4:0]  round_b;

  keccak_rc_lfsr_gen #(.NR(NR_A), .LANE_W(LW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .rc_ready(ready_a), .rc_valid(valid_a),
    .rc_data(data_a), .rc_round(round_a), .rc_last(last_a), .busy(busy_a), .done(done_a));

  keccak_rc_lfsr_gen #(.NR(NR_B), .LANE_W(LW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .rc_ready(ready_b), .rc_valid(valid_b),
    .rc_data(data_b), .rc_round(round_b), .rc_last(last_b), .busy(busy_b), .done(done_b));

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  round;
    logic        last;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int errors = 0;
  int hs_a = 0, hs_b = 0, dn_a = 0, dn_b = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rc(t) = bit 0 of x^t mod (x^8+x^6+x^5+x^4+1)
  function automatic logic rc_bit(input int t);
    logic [8:0] r;
    r = 9'h001;
    for (int i = 0; i < t % 255; i++) begin
      r = r << 1;
      if (r[8]) r = r ^ 9'h171;
    end
    return r[0];
  endfunction

  function automatic logic [63:0] ref_rc(input int ir);
    logic [63:0] c;
    c = 64'd0;
    for (int j = 0; j < 7; j++) c[(1 << j) - 1] = rc_bit(7 * ir + j);
    return c;
  endfunction

  function automatic logic known_a(input int r, output logic [63:0] v);
    known_a = 1'b1;
    case (r)
      0:       v = 64'h0000000000000001;
      1:       v = 64'h0000000000008082;
      2:       v = 64'h800000000000808A;
      5:       v = 64'h0000000080000001;
      6:       v = 64'h8000000080008081;
      23:      v = 64'h8000000080008008;
      default: begin v = 64'd0; known_a = 1'b0; end
    endcase
  endfunction

  function automatic logic known_b(input int r, output logic [63:0] v);
    known_b = 1'b1;
    case (r)
      0:       v = 64'h0001;
      1:       v = 64'h8082;
      11:      v = 64'h000A;
      default: begin v = 64'd0; known_b = 1'b0; end
    endcase
  endfunction

  task automatic push_seq(input logic which, input int nr, input int lw);
    exp_t e;
    logic [63:0] v;
    for (int r = 0; r < nr; r++) begin
      v = ref_rc(r);
      if (lw < 64) v = v & ((64'd1 << lw) - 64'd1);
      e.data  = v;
      e.round = 5'(r);
      e.last  = (r == nr - 1);
      if (which) q_b.push_back(e);
      else q_a.push_back(e);
    end
  endtask

  // Monitor A: handshakes against the scoreboard, hold-stability, done timing.
  initial begin : mon_a
    logic stall, last_hs, pl;
    logic [63:0] pd, kv;
    logic [4:0] pr;
    exp_t e;
    stall = 1'b0; last_hs = 1'b0; pd = 64'd0; pr = 5'd0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
        last_hs = 1'b0;
      end else begin
        chk("done_a pulse", 64'(done_a), 64'(last_hs));
        if (done_a) dn_a++;
        if (stall) begin
          chk("hold valid_a", 64'(valid_a), 64'd1);
          chk("hold data_a", data_a, pd);
          chk("hold round_a", 64'(round_a), 64'(pr));
          chk("hold last_a", 64'(last_a), 64'(pl));
        end
        if (valid_a && ready_a) begin
          hs_a++;
          if (q_a.size() == 0) begin
            chk("unexpected output a", 64'(q_a.size()), 64'd1);
          end else begin
            e = q_a.pop_front();
            chk("data_a", data_a, e.data);
            chk("round_a", 64'(round_a), 64'(e.round));
            chk("last_a", 64'(last_a), 64'(e.last));
            if (known_a(int'(e.round), kv)) chk("known const a", data_a, kv);
          end
          last_hs = last_a;
          stall = 1'b0;
        end else begin
          last_hs = 1'b0;
          stall = valid_a && !ready_a;
          pd = data_a; pr = round_a; pl = last_a;
        end
      end
    end
  end

  // Monitor B: handshakes against the scoreboard and done timing.
  initial begin : mon_b
    logic last_hs;
    logic [63:0] kv;
    exp_t e;
    last_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_hs = 1'b0;
      end else begin
        chk("done_b pulse", 64'(done_b), 64'(last_hs));
        if (done_b) dn_b++;
        if (valid_b && ready_b) begin
          hs_b++;
          if (q_b.size() == 0) begin
            chk("unexpected output b", 64'(q_b.size()), 64'd1);
          end else begin
            e = q_b.pop_front();
            chk("data_b", 64'(data_b), e.data);
            chk("round_b", 64'(round_b), 64'(e.round));
            chk("last_b", 64'(last_b), 64'(e.last));
            if (known_b(int'(e.round), kv)) chk("known const b", 64'(data_b), kv);
          end
          last_hs = last_b;
        end else begin
          last_hs = 1'b0;
        end
      end
    end
  end

  task automatic launch_a(output int lat);
    push_seq(1'b0, NR_A, LW_A);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("busy_a at S", 64'(busy_a), 64'd1);
    lat = 0;
    while (!valid_a && lat < 50) begin
      tick();
      lat++;
    end
    chk("first valid latency a", 64'(lat), 64'(LAT));
  endtask

  task automatic launch_b(output int lat);
    push_seq(1'b1, NR_B, LW_B);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("busy_b at S", 64'(busy_b), 64'd1);
    lat = 0;
    while (!valid_b && lat < 50) begin
      tick();
      lat++;
    end
    chk("first valid latency b", 64'(lat), 64'(LAT));
  endtask

  task automatic wait_hs_a(input int target);
    int k;
    k = 0;
    while (hs_a < target && k < 2000) begin
      tick();
      k++;
    end
    chk("reach handshake count a", 64'(hs_a >= target), 64'd1);
  endtask

  task automatic check_reset_state();
    chk("rst valid_a", 64'(valid_a), 64'd0);
    chk("rst data_a", data_a, 64'd0);
    chk("rst round_a", 64'(round_a), 64'd0);
    chk("rst last_a", 64'(last_a), 64'd0);
    chk("rst busy_a", 64'(busy_a), 64'd0);
    chk("rst done_a", 64'(done_a), 64'd0);
  endtask

  initial begin : stim
    int base, lat, cyc, k;
    rst_n = 1'b0; start_a = 1'b0; ready_a = 1'b0; start_b = 1'b0; ready_b = 1'b0;
    repeat (3) tick();
    check_reset_state();
    chk("rst valid_b", 64'(valid_b), 64'd0);
    chk("rst data_b", 64'(data_b), 64'd0);
    chk("rst busy_b", 64'(busy_b), 64'd0);
    rst_n = 1'b1;
    tick();

    // Abort after three accepted constants.
    ready_a = 1'b1;
    launch_a(lat);
    wait_hs_a(3);
    rst_n = 1'b0;
    tick();
    check_reset_state();
    q_a.delete();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("quiet after abort valid", 64'(valid_a), 64'd0);
    chk("quiet after abort busy", 64'(busy_a), 64'd0);

    // Full sequence with rc_ready high; check end-to-end timing.
    base = hs_a;
    launch_a(lat);
    cyc = lat;
    while (!done_a && cyc < 1000) begin
      tick();
      cyc++;
    end
    chk("done edge a", 64'(cyc), 64'(LAT + 1 + (NR_A - 1) * PER));
    chk("busy low with done a", 64'(busy_a), 64'd0);
    chk("handshakes full a", 64'(hs_a - base), 64'(NR_A));

    // Restart at the earliest edge, stall on round 5, stray start at round 10.
    base = hs_a;
    launch_a(lat);
    wait_hs_a(base + 5);
    ready_a = 1'b0;
    repeat (10) tick();
    chk("stall valid r5", 64'(valid_a), 64'd1);
    chk("stall round r5", 64'(round_a), 64'd5);
    chk("stall data r5", data_a, 64'h0000000080000001);
    ready_a = 1'b1;
    k = 0;
    while (hs_a < base + 10 && k < 2000) begin
      ready_a = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("busy during stray start", 64'(busy_a), 64'd1);
    k = 0;
    while (!done_a && k < 3000) begin
      ready_a = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    chk("done reached a", 64'(done_a), 64'd1);
    chk("handshakes with stray start", 64'(hs_a - base), 64'(NR_A));
    chk("scoreboard empty a", 64'(q_a.size()), 64'd0);
    ready_a = 1'b0;
    repeat (4) tick();
    chk("no restart after stray start", 64'(busy_a), 64'd0);

    // Narrow instance: random backpressure, then ready held high.
    for (int s = 0; s < 2; s++) begin
      base = hs_b;
      ready_b = 1'(s);
      launch_b(lat);
      k = 0;
      while (!done_b && k < 3000) begin
        if (s == 0) ready_b = 1'($urandom_range(0, 1));
        tick();
        k++;
      end
      chk("done reached b", 64'(done_b), 64'd1);
      chk("handshakes b", 64'(hs_b - base), 64'(NR_B));
      tick();
    end
    chk("scoreboard empty b", 64'(q_b.size()), 64'd0);
    chk("done pulses a", 64'(dn_a), 64'd2);
    chk("done pulses b", 64'(dn_b), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
